// File: rtl/mdr_pkg.sv
// rtl/mdr_pkg.sv - shared op and state types for the MDR request arbiter
package mdr_pkg;

    typedef enum logic [1:0] {
        OP_MUL  = 2'd0,
        OP_DIV  = 2'd1,
        OP_SQRT = 2'd2,
        OP_RSVD = 2'd3
    } mdr_op_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_e;

endpackage

// File: rtl/mdr_rr_picker.sv
// rtl/mdr_rr_picker.sv - combinational round-robin winner select starting at ptr
module mdr_rr_picker #(
    parameter int N_REQ = 2,
    parameter int IW    = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic             any_req,
    output logic [IW-1:0]    winner
);

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   rot;
    logic [IW-1:0]      rot_idx;
    logic [IW:0]        sum;

    always_comb begin
        req_dbl = {req, req};
        rot     = req_dbl[ptr +: N_REQ];
        rot_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) rot_idx = IW'(i);
        end
        // Un-rotate: the rotated index is relative to ptr, wrap modulo N_REQ.
        sum     = {1'b0, rot_idx} + {1'b0, ptr};
        winner  = (sum >= (IW+1)'(N_REQ)) ? IW'(sum - (IW+1)'(N_REQ)) : IW'(sum);
        any_req = |req;
    end

endmodule

// File: rtl/mdr_req_arbiter.sv
// rtl/mdr_req_arbiter.sv - round-robin sharing of one MDR unit between N_REQ requesters
module mdr_req_arbiter
    import mdr_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int DW          = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*DW-1:0]        req_x,
    input  logic [N_REQ*DW-1:0]        req_y,
    input  logic [N_REQ*2-1:0]         req_op,
    output logic [N_REQ-1:0]           req_grant,
    output logic                       mdr_start,
    output logic [DW-1:0]              mdr_x,
    output logic [DW-1:0]              mdr_y,
    output logic [1:0]                 mdr_op,
    output logic                       mdr_abort,
    input  logic                       mdr_ready,
    input  logic                       mdr_error,
    input  logic [DW-1:0]              mdr_result,
    output logic                       rsp_valid,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic [DW-1:0]              rsp_result,
    output logic                       rsp_error,
    output logic                       rsp_timeout,
    output logic                       busy
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    arb_state_e     state;
    logic [IW-1:0]  ptr;
    logic [CW-1:0]  cnt;
    logic           any_req;
    logic [IW-1:0]  winner;
    logic [1:0]     win_op;

    assign win_op = req_op[winner*2 +: 2];

    mdr_rr_picker #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_picker (
        .req     (req_valid),
        .ptr     (ptr),
        .any_req (any_req),
        .winner  (winner)
    );

    // Grant and start are registered at the capture edge so they are seen during ISSUE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            cnt         <= '0;
            req_grant   <= '0;
            mdr_start   <= 1'b0;
            mdr_x       <= '0;
            mdr_y       <= '0;
            mdr_op      <= '0;
            mdr_abort   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_result  <= '0;
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            req_grant <= '0;
            mdr_start <= 1'b0;
            mdr_abort <= 1'b0;
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        mdr_x     <= req_x[winner*DW +: DW];
                        mdr_y     <= req_y[winner*DW +: DW];
                        mdr_op    <= win_op;
                        rsp_id    <= winner;
                        req_grant <= N_REQ'(1) << winner;
                        mdr_start <= (win_op != OP_RSVD);
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt <= '0;
                    if (mdr_op == OP_RSVD) begin
                        rsp_error   <= 1'b1;
                        rsp_result  <= '0;
                        rsp_timeout <= 1'b0;
                        state       <= RESP;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (mdr_error) begin
                        rsp_error   <= 1'b1;
                        rsp_result  <= '0;
                        rsp_timeout <= 1'b0;
                        state       <= RESP;
                    end else if (mdr_ready) begin
                        rsp_error   <= 1'b0;
                        rsp_result  <= mdr_result;
                        rsp_timeout <= 1'b0;
                        state       <= RESP;
                    end else if (cnt == CW'(TIMEOUT_CYC - 2)) begin
                        // The incremented count would reach TIMEOUT_CYC-1 this edge.
                        mdr_abort   <= 1'b1;
                        rsp_error   <= 1'b1;
                        rsp_result  <= '0;
                        rsp_timeout <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b1;
                    ptr       <= (rsp_id == IW'(N_REQ - 1)) ? '0 : rsp_id + 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdr_req_arbiter.sv
// tb/tb_mdr_req_arbiter.sv - randomized self-checking bench for mdr_req_arbiter
module tb_mdr_req_arbiter;
    import mdr_pkg::*;

    localparam int N  = 2;
    localparam int DW = 16;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N*DW-1:0]   req_x = '0;
    logic [N*DW-1:0]   req_y = '0;
    logic [N*2-1:0]    req_op = '0;
    logic [N-1:0]      req_grant;
    logic              mdr_start;
    logic [DW-1:0]     mdr_x;
    logic [DW-1:0]     mdr_y;
    logic [1:0]        mdr_op;
    logic              mdr_abort;
    logic              mdr_ready = 1'b0;
    logic              mdr_error = 1'b0;
    logic [DW-1:0]     mdr_result = '0;
    logic              rsp_valid;
    logic [0:0]        rsp_id;
    logic [DW-1:0]     rsp_result;
    logic              rsp_error;
    logic              rsp_timeout;
    logic              busy;

    mdr_req_arbiter #(.N_REQ(N), .DW(DW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
        .req_op(req_op), .req_grant(req_grant), .mdr_start(mdr_start), .mdr_x(mdr_x),
        .mdr_y(mdr_y), .mdr_op(mdr_op), .mdr_abort(mdr_abort), .mdr_ready(mdr_ready),
        .mdr_error(mdr_error), .mdr_result(mdr_result), .rsp_valid(rsp_valid),
        .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_error(rsp_error),
        .rsp_timeout(rsp_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_pass   = 0;
    bit            pend [N];
    logic [DW-1:0] px   [N];
    logic [DW-1:0] py   [N];
    logic [1:0]    pop  [N];
    int            ptr_m = 0;
    logic [N-1:0]  grant_log [$];
    int            id_log    [$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
    endtask

    function automatic logic [DW-1:0] mdr_calc(input logic [1:0] op, input logic [DW-1:0] x,
                                               input logic [DW-1:0] y);
        logic [2*DW-1:0] p;
        int r;
        p = x * y;
        r = 0;
        case (op)
            OP_MUL:  return p[DW-1:0];
            OP_DIV:  return (y == '0) ? '0 : x / y;
            OP_SQRT: begin
                while ((r + 1) * (r + 1) <= int'(x)) r++;
                return DW'(r);
            end
            default: return '0;
        endcase
    endfunction

    task automatic drive_reqs(input logic [N-1:0] noise);
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = pend[i] | noise[i];
            req_x[i*DW +: DW]     = px[i];
            req_y[i*DW +: DW]     = py[i];
            req_op[i*2 +: 2]      = pop[i];
        end
    endtask

    task automatic new_req(input int i);
        pend[i] = 1'b1;
        px[i]   = DW'($urandom);
        py[i]   = ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom);
        pop[i]  = 2'($urandom_range(0, 3));
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        drive_reqs('0);
        mdr_ready = 1'b0;
        mdr_error = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {req_grant, mdr_start, mdr_x, mdr_y, mdr_op, mdr_abort, rsp_valid,
                                rsp_id, rsp_result, rsp_error, rsp_timeout, busy}, '0);
        rst   = 1'b0;
        ptr_m = 0;
    endtask

    // k: cycles from start pulse to MDR ready; k >= TO means the MDR never answers.
    task automatic do_txn(input int k, input bit inj_err, input bit spur, input logic [N-1:0] noise);
        int            w = -1;
        bit            rsvd, tmo, err;
        logic [DW-1:0] res;
        int            exp_r, rsp_cyc = -1, aborts = 0, abort_cyc = -1, starts = 0;
        logic [DW-1:0] got_res = '0;
        logic          got_id = 1'b0, got_err = 1'b0, got_to = 1'b0, got_busy = 1'b1;

        for (int i = 0; i < N; i++) if (w < 0 && pend[(ptr_m + i) % N]) w = (ptr_m + i) % N;
        if (w < 0) begin
            $display("FAIL txn_setup: no pending request");
            $fatal(1);
        end
        rsvd  = (pop[w] == OP_RSVD);
        tmo   = !rsvd && (k >= TO);
        err   = !rsvd && !tmo && (inj_err || (pop[w] == OP_DIV && py[w] == '0));
        res   = (rsvd || tmo || err) ? '0 : mdr_calc(pop[w], px[w], py[w]);
        exp_r = rsvd ? 2 : (tmo ? TO + 1 : k + 2);

        @(posedge clk); #1;
        grant_log.push_back(req_grant);
        check("grant", req_grant, 64'(1) << w);
        check("start", mdr_start, !rsvd);
        check("busy_issue", busy, 1);
        check("cap_id", rsp_id, w);
        check("cap_x", mdr_x, px[w]);
        check("cap_y", mdr_y, py[w]);
        check("cap_op", mdr_op, pop[w]);
        pend[w] = 1'b0;
        drive_reqs(noise);
        mdr_ready  = spur;
        mdr_error  = spur;
        mdr_result = DW'($urandom);

        for (int c = 1; c <= TO + 4 && rsp_cyc < 0; c++) begin
            @(posedge clk); #1;
            if (c == 1) check("grant_one_cycle", req_grant, 0);
            starts += int'(mdr_start);
            aborts += int'(mdr_abort);
            if (mdr_abort && abort_cyc < 0) abort_cyc = c;
            if (rsp_valid) begin
                rsp_cyc  = c;
                got_id   = rsp_id;
                got_res  = rsp_result;
                got_err  = rsp_error;
                got_to   = rsp_timeout;
                got_busy = busy;
            end
            drive_reqs('0);
            if (c == k && !rsvd && !tmo) begin
                mdr_ready  = 1'b1;
                mdr_error  = err;
                mdr_result = err ? DW'($urandom | 1) : res;
            end else begin
                mdr_ready  = 1'b0;
                mdr_error  = 1'b0;
                mdr_result = DW'($urandom);
            end
        end
        id_log.push_back(int'(got_id));
        check("rsp_cycle", rsp_cyc, exp_r);
        check("rsp_id", got_id, w);
        check("rsp_result", got_res, res);
        check("rsp_error", got_err, rsvd || tmo || err);
        check("rsp_timeout", got_to, tmo);
        check("busy_at_rsp", got_busy, 0);
        check("abort_count", aborts, tmo);
        check("extra_start", starts, 0);
        if (tmo) check("abort_cycle", abort_cyc, TO);
        ptr_m = (w + 1) % N;
    endtask

    initial begin
        logic [N-1:0] exp_grants [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        int           exp_ids    [4] = '{0, 1, 0, 1};
        int           seen;
        bit           any;
        int           k;

        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; px[i] = '0; py[i] = '0; pop[i] = OP_MUL;
        end
        reset_dut();

        // Single MUL, ready two cycles after start.
        pend[0] = 1'b1; px[0] = 16'd7; py[0] = 16'd6; pop[0] = OP_MUL;
        drive_reqs('0);
        do_txn(2, 1'b0, 1'b0, '0);

        // Contention from both requesters, each re-requesting after its response.
        reset_dut();
        grant_log.delete();
        id_log.delete();
        for (int i = 0; i < N; i++) new_req(i);
        for (int i = 0; i < N; i++) pop[i] = OP_MUL;
        drive_reqs('0);
        for (int t = 0; t < 4; t++) begin
            do_txn(1 + t, 1'b0, 1'b0, '0);
            if (t < 3) pend[id_log[t]] = 1'b1;
            drive_reqs('0);
        end
        for (int t = 0; t < 4; t++) begin
            check("contention_grant", grant_log[t], exp_grants[t]);
            check("contention_id", id_log[t], exp_ids[t]);
        end

        // Error and ready together resolve as error.
        px[0] = 16'd9; py[0] = 16'd0; pop[0] = OP_DIV; pend[0] = 1'b1;
        drive_reqs('0);
        do_txn(1, 1'b1, 1'b0, '0);

        // Reserved op from requester 1 never reaches the MDR.
        px[1] = 16'd3; py[1] = 16'd4; pop[1] = OP_RSVD; pend[1] = 1'b1;
        drive_reqs('0);
        do_txn(1, 1'b0, 1'b0, '0);

        // MDR never answers.
        px[0] = 16'd100; py[0] = 16'd5; pop[0] = OP_DIV; pend[0] = 1'b1;
        drive_reqs('0);
        do_txn(100, 1'b0, 1'b0, '0);

        // Reset during WAIT drops the transaction and the pointer.
        px[1] = 16'd5; py[1] = 16'd5; pop[1] = OP_MUL; pend[1] = 1'b1;
        drive_reqs('0);
        @(posedge clk); #1;
        check("midrst_grant", req_grant, 2'b10);
        pend[1] = 1'b0;
        drive_reqs('0);
        @(posedge clk); #1;
        check("midrst_busy_wait", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_outputs", {req_grant, mdr_start, mdr_x, mdr_y, mdr_op, mdr_abort, rsp_valid,
                                 rsp_id, rsp_result, rsp_error, rsp_timeout, busy}, '0);
        rst   = 1'b0;
        ptr_m = 0;
        mdr_ready = 1'b1;
        mdr_result = 16'h1234;
        seen = 0;
        repeat (TO + 2) begin
            @(posedge clk); #1;
            mdr_ready = 1'b0;
            seen += int'(rsp_valid) + int'(mdr_abort) + int'(busy);
        end
        check("midrst_quiet", seen, 0);
        new_req(0);
        new_req(1);
        pop[0] = OP_MUL;
        drive_reqs('0);
        do_txn(3, 1'b0, 1'b0, '0);

        // Randomized traffic.
        for (int t = 0; t < 150; t++) begin
            for (int i = 0; i < N; i++) if (!pend[i] && $urandom_range(0, 1) == 1) new_req(i);
            any = 1'b0;
            for (int i = 0; i < N; i++) any |= pend[i];
            if (!any) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                    check("idle_busy", busy, 0);
                    check("idle_grant", req_grant, 0);
                end
                new_req($urandom_range(0, N - 1));
            end
            drive_reqs('0);
            k = ($urandom_range(0, 9) == 0) ? 100 : $urandom_range(1, TO - 1);
            do_txn(k, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, N'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mdr_req_arbiter.md
Name: mdr_req_arbiter

Overview:
- Shares the single multiply/divide/root (MDR) unit between N_REQ independent requesters.
- Captures one request at a time with round-robin fairness and issues a one-cycle start with the operands and op to the MDR.
- Waits for the MDR's ready or error and returns a tagged response pulse to the requester that won.
- Enforces a completion timeout and rejects reserved op codes without touching the MDR.

Parameters:
- N_REQ, 2: number of requesters (2..4).
- DW, 16: operand and result width.
- TIMEOUT_CYC, 64: maximum cycles in WAIT before a timeout abort (≥2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  N_REQ  per-requester request; held high until granted.
- req_x  in  N_REQ*DW  flattened X operands; requester i occupies bits [i*DW +: DW].
- req_y  in  N_REQ*DW  flattened Y operands, same layout.
- req_op  in  N_REQ*2  flattened op codes (mdr_op_e).
- req_grant  out  N_REQ  one-hot, one-cycle pulse: operands of that requester were captured.
- mdr_start  out  1  one-cycle start pulse to the MDR.
- mdr_x  out  DW  captured X, stable from ISSUE until return to IDLE.
- mdr_y  out  DW  captured Y, same stability.
- mdr_op  out  2  captured op, same stability.
- mdr_abort  out  1  one-cycle pulse on timeout.
- mdr_ready  in  1  MDR done.
- mdr_error  in  1  MDR error.
- mdr_result  in  DW  MDR result; valid with mdr_ready.
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_id  out  $clog2(N_REQ)  index of the served requester.
- rsp_result  out  DW  result; 0 on any error.
- rsp_error  out  1  MDR error, reserved op, or timeout.
- rsp_timeout  out  1  set only on timeout.
- busy  out  1  high whenever the arbiter is not in IDLE.

Behaviour:
- Reset: synchronous; rst high at a clock edge forces IDLE. All outputs are registered and go to 0 at reset. The round-robin pointer resets to 0 and the timeout counter clears.
- Reset mid-operation: an active transaction is dropped silently. No rsp_valid and no mdr_abort are produced.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, the picker selects the winner starting from the pointer.
  - Latch the winner's x, y and op, and latch the winner index into rsp_id.
  - Next state is ISSUE.
- ISSUE (one cycle):
  - req_grant[winner] = 1.
  - If op = OP_RSVD: no mdr_start; set rsp_error, clear rsp_result; next state RESP.
  - Otherwise: mdr_start = 1, clear the timeout counter; next state WAIT.
- WAIT (counter increments each cycle), first match wins:
  1. mdr_error: rsp_error = 1, rsp_result = 0.
  2. mdr_ready: rsp_result = mdr_result, rsp_error = 0.
  3. Counter reaches TIMEOUT_CYC-1: mdr_abort = 1, rsp_error = 1, rsp_timeout = 1, rsp_result = 0.
  - Any of the three moves to RESP. mdr_error and mdr_ready in the same cycle resolve as error.
- RESP (one cycle): rsp_valid = 1; pointer = (winner+1) mod N_REQ; next state IDLE.
- Latency (no contention, MDR ready seen k cycles after the start pulse): rsp_valid comes k+2 cycles after the IDLE capture edge. Minimum request-to-response is 3 cycles. A reserved op responds 2 cycles after capture.
- Requesters must drop req_valid the cycle after their grant. A request still held when the arbiter is back in IDLE is treated as a new request.
- req_valid changing while the arbiter is busy is ignored. Only the IDLE-cycle sample is arbitrated.
- Fairness: a continuously requesting requester waits at most N_REQ-1 transactions.
- mdr_ready or mdr_error outside WAIT is ignored.

Decomposition:
- Shared package mdr_pkg:
  - mdr_op_e: OP_MUL=0, OP_DIV=1, OP_SQRT=2, OP_RSVD=3.
  - arb_state_e: IDLE, ISSUE, WAIT, RESP.
- One sub-module, mdr_rr_picker, purely combinational:
  - inputs: req vector, pointer.
  - outputs: any_req, winner index.
  - behaviour: rotate, priority-encode, un-rotate.
- The FSM, operand registers, timeout counter and response registers live in mdr_req_arbiter.

Test Plan:
1. Reset/single MUL: rst held 2 cycles, then req_valid=01 with x=7, y=6, op=MUL; MDR model asserts ready=1, result=42 two cycles after start. Required: grant=01 for 1 cycle, one start pulse, rsp_valid with id=0, result=42, error=0 exactly 4 cycles after the capture edge.
2. Contention: req_valid=11 held, each requester re-asserts after its response, 4 transactions. Required: grant order 0,1,0,1; rsp_id sequence 0,1,0,1.
3. Error priority: DIV with x=9, y=0; MDR asserts error=1 and ready=1 in the same cycle. Required: rsp_error=1, rsp_result=0, rsp_timeout=0.
4. Timeout: TIMEOUT_CYC=8, MDR never responds. Required: mdr_abort pulse exactly 8 cycles after start, then rsp_valid with error=1, timeout=1.
5. Reserved op: op=3 from requester 1. Required: grant=10, no mdr_start, rsp_valid with id=1, error=1 two cycles after capture.
6. Mid-op reset: rst asserted during WAIT. Required: next cycle all outputs 0, busy=0, no rsp_valid; the next request is served normally with pointer=0.
